// File: rtl/sig_splice_pkg.sv
// Shared types and helpers for the sig_splice packer: slot encoding, lane width, parity.
package sig_splice_pkg;

    typedef enum logic [1:0] {
        SLOT_I0_LO = 2'd0,
        SLOT_I1_LO = 2'd1,
        SLOT_I0_HI = 2'd2,
        SLOT_I1_HI = 2'd3
    } slot_e;

    function automatic int lane_w_of(input int data_w);
        return data_w / 2;
    endfunction

    // Even parity bit: set when the word holds an odd number of ones.
    function automatic logic even_par(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sig_splice_outreg.sv
// Output holding register for the packer: pair data, valid flag and (with
// SIG_SPLICE_PARITY_EN) the registered parity bits.
module sig_splice_outreg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              out_ready,
    input  logic [DATA_W-1:0] ld_i0,
    input  logic [DATA_W-1:0] ld_i1,
`ifdef SIG_SPLICE_PARITY_EN
    input  logic [1:0]        ld_par,
    output logic [1:0]        out_par,
`endif
    output logic [DATA_W-1:0] out_i0,
    output logic [DATA_W-1:0] out_i1,
    output logic              out_valid
);

    logic [DATA_W-1:0] out_i0_q, out_i0_d;
    logic [DATA_W-1:0] out_i1_q, out_i1_d;
    logic              out_valid_q, out_valid_d;
`ifdef SIG_SPLICE_PARITY_EN
    logic [1:0]        out_par_q, out_par_d;
`endif

    always_comb begin
        out_i0_d    = out_i0_q;
        out_i1_d    = out_i1_q;
        out_valid_d = out_valid_q;
`ifdef SIG_SPLICE_PARITY_EN
        out_par_d   = out_par_q;
`endif
        if (load) begin
            out_i0_d    = ld_i0;
            out_i1_d    = ld_i1;
            out_valid_d = 1'b1;
`ifdef SIG_SPLICE_PARITY_EN
            out_par_d   = ld_par;
`endif
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_i0_q    <= '0;
            out_i1_q    <= '0;
            out_valid_q <= 1'b0;
`ifdef SIG_SPLICE_PARITY_EN
            out_par_q   <= 2'b00;
`endif
        end else begin
            out_i0_q    <= out_i0_d;
            out_i1_q    <= out_i1_d;
            out_valid_q <= out_valid_d;
`ifdef SIG_SPLICE_PARITY_EN
            out_par_q   <= out_par_d;
`endif
        end
    end

    assign out_i0    = out_i0_q;
    assign out_i1    = out_i1_q;
    assign out_valid = out_valid_q;
`ifdef SIG_SPLICE_PARITY_EN
    assign out_par   = out_par_q;
`endif

endmodule

// File: rtl/sig_splice_packer.sv
// Nibble-stream to (i0,i1) byte-pair packer feeding the sig_splice datapath.
// Optional macro SIG_SPLICE_PARITY_EN adds the registered out_par port.
module sig_splice_packer
    import sig_splice_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [lane_w_of(DATA_W)-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_W-1:0]          out_i0,
    output logic [DATA_W-1:0]          out_i1,
`ifdef SIG_SPLICE_PARITY_EN
    output logic [1:0]                 out_par,
`endif
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int LANE_W = lane_w_of(DATA_W);

    logic [1:0]        cnt_q, cnt_d;
    logic              asm_full_q, asm_full_d;
    logic [DATA_W-1:0] asm_i0_q, asm_i0_d;
    logic [DATA_W-1:0] asm_i1_q, asm_i1_d;
    logic              xfer;
    logic              in_fire;
    logic              out_valid_w;

    // xfer needs asm_full already set, so it never races the slot3 fill.
    assign xfer     = asm_full_q && (!out_valid_w || out_ready);
    assign in_ready = !asm_full_q || xfer;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        cnt_d      = cnt_q;
        asm_full_d = asm_full_q;
        asm_i0_d   = asm_i0_q;
        asm_i1_d   = asm_i1_q;
        if (xfer) begin
            asm_full_d = 1'b0;
        end
        if (in_fire) begin
            cnt_d = cnt_q + 2'd1;
            unique case (slot_e'(cnt_q))
                SLOT_I0_LO: asm_i0_d[LANE_W-1:0]      = in_data;
                SLOT_I1_LO: asm_i1_d[LANE_W-1:0]      = in_data;
                SLOT_I0_HI: asm_i0_d[DATA_W-1:LANE_W] = in_data;
                SLOT_I1_HI: begin
                    asm_i1_d[DATA_W-1:LANE_W] = in_data;
                    asm_full_d                = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 2'd0;
            asm_full_q <= 1'b0;
            asm_i0_q   <= '0;
            asm_i1_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            asm_full_q <= asm_full_d;
            asm_i0_q   <= asm_i0_d;
            asm_i1_q   <= asm_i1_d;
        end
    end

`ifdef SIG_SPLICE_PARITY_EN
    logic [1:0] asm_par;
    assign asm_par = {even_par(64'(asm_i1_q)), even_par(64'(asm_i0_q))};
`endif

    sig_splice_outreg #(
        .DATA_W (DATA_W)
    ) u_outreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (xfer),
        .out_ready (out_ready),
        .ld_i0     (asm_i0_q),
        .ld_i1     (asm_i1_q),
`ifdef SIG_SPLICE_PARITY_EN
        .ld_par    (asm_par),
        .out_par   (out_par),
`endif
        .out_i0    (out_i0),
        .out_i1    (out_i1),
        .out_valid (out_valid_w)
    );

    assign out_valid = out_valid_w;

endmodule

// File: doc/sig_splice_packer.md
Name: sig_splice_packer

Overview:
- Upstream feeder for the sig_splice datapath.
- Accepts a valid/ready stream of nibbles and interleave-assembles every four nibbles into a pair of bytes (out_i0, out_i1) that drive the splice stage's i0/i1 inputs.
- Double-buffered: one assembly register plus one output register, so full throughput is sustained under continuous ready.

Parameters:
- DATA_W, 8, width of each output word; must be even and at least 2.
- LANE_W, DATA_W/2, nibble width (derived; not overridable).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  LANE_W  incoming nibble.
- in_valid  input  1  in_data valid.
- in_ready  output  1  packer can accept in_data this cycle.
- out_i0  output  DATA_W  assembled word 0.
- out_i1  output  DATA_W  assembled word 1.
- out_valid  output  1  out_i0/out_i1 hold a complete pair.
- out_ready  input  1  consumer takes the pair this cycle.
- out_par  output  2  present only with SIG_SPLICE_PARITY_EN: {even parity of out_i1, even parity of out_i0}.

Behaviour:
- Reset, asynchronous, rst_n=0:
  - slot counter cnt[1:0]=0, asm_full=0, assembly regs=0.
  - out_i0=0, out_i1=0, out_valid=0, out_par=0.
  - Deassertion takes effect on the next clk edge. Reset mid-group discards the partial nibbles and any held pair.
- Input fire = in_valid && in_ready. Nibble goes to slot cnt:
  - slot0 → asm_i0[LANE_W-1:0]
  - slot1 → asm_i1[LANE_W-1:0]
  - slot2 → asm_i0[DATA_W-1:LANE_W]
  - slot3 → asm_i1[DATA_W-1:LANE_W]
  - cnt increments and wraps 3→0. Firing slot3 sets asm_full.
- Transfer condition: xfer = asm_full && (!out_valid || out_ready).
  - On xfer: out regs <= asm regs, out_valid<=1, asm_full<=0.
  - Else if out_valid && out_ready: out_valid<=0.
- in_ready = !asm_full || xfer (combinational).
  - A nibble accepted in the xfer cycle writes slot0 of the next group.
  - Same-cycle asm_full set (slot3 fire) and clear (xfer) cannot collide, because xfer requires asm_full already set.
- Latency: slot3 accepted at edge N → asm_full at N → out_valid visible after edge N+1.
- Throughput: one nibble per cycle sustained with out_ready=1.
- Backpressure:
  - With out_valid=1, out_ready=0 and asm_full=1, in_ready=0 and all state holds.
  - out_i0/out_i1 stay stable while out_valid && !out_ready.
- in_valid without in_ready: no state change. Data is don't-care when in_valid=0.
- No partial-group flush: a group is emitted only after 4 nibbles.

Optional Feature:
- Macro SIG_SPLICE_PARITY_EN.
- When defined:
  - out_par port exists.
  - Parity is computed from asm regs and registered alongside out_i0/out_i1 on xfer.
  - out_par is 0 on reset and obeys the same hold rules as the data.
- When undefined: port and parity logic are absent. Data timing is identical either way.

Decomposition:
- Package sig_splice_pkg:
  - LANE_W derivation helper.
  - Slot enum SLOT_I0_LO, SLOT_I1_LO, SLOT_I0_HI, SLOT_I1_HI (2-bit).
  - Parity function.
- One sub-module, sig_splice_outreg:
  - Holds out_i0/out_i1/out_par and out_valid.
  - Takes load and out_ready, exports out_valid for the xfer computation.
- Slot decode and counter stay in the top module.

Test Plan:
- Basic assembly: reset, send 0x1,0x2,0x3,0x4 with out_ready=1 → out_i0=0x31, out_i1=0x42, out_valid high one cycle, two edges after the 4th accept.
- Streaming: 16 back-to-back nibbles 0x0..0xF, out_ready=1 → in_ready never drops; four pairs emitted: (0x20,0x31), (0x64,0x75), (0xA8,0xB9), (0xEC,0xFD).
- Backpressure: out_ready=0, send 8 nibbles → first pair held stable, second group assembled, in_ready=0 after the 8th. Raise out_ready → pairs drain in order, then in_ready=1.
- Reset mid-group: send 0x5,0x6, assert rst_n=0 asynchronously between edges → all outputs 0 immediately. After release, 0x1..0x4 → out_i0=0x31, out_i1=0x42.
- Parity (SIG_SPLICE_PARITY_EN): nibbles 0x7,0x1,0x0,0x0 → out_i0=0x07, out_i1=0x01, out_par=2'b11. Nibbles 0x3,0x0,0x0,0x0 → out_par=2'b00.
- Idle gaps: random in_valid gaps between nibbles → output values identical to the gap-free run, and cnt unchanged during gaps.
